saa1099_bus_sched: RTL

- Schedules all register writes into the saa1099 sound generator. It shares the chip's write port between two requesters:
  - a direct CPU port;
  - a buffered sequencer/player port that queues up to FIFO_DEPTH writes.
- Each request is a (register, data) pair. The block expands it into a SAA1099 address phase and data phase, with correct cs_n/a0/wr_n strobes.
- It caches the last latched address so that a repeated address phase can be skipped.
- Address-only operations are always issued, because an address write to 0x18/0x19 is the external envelope clock.

---
 rtl/saa1099_pkg.sv | 25 ++
 rtl/saa1099_op_fifo.sv | 74 +++++++
 rtl/saa1099_bus_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/saa1099_pkg.sv
// Shared types for the SAA1099 write-port scheduler.
// Op bundle, scheduler states and well-known register numbers.
package saa1099_pkg;

  localparam logic [4:0] REG_ENV0 = 5'h18;
  localparam logic [4:0] REG_ENV1 = 5'h19;
  localparam logic [4:0] REG_CTRL = 5'h1C;

  typedef struct packed {
    logic       addr_only;
    logic [4:0] rsel;
    logic [7:0] data;
  } saa_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD
  } state_e;

endpackage

// File: rtl/saa1099_op_fifo.sv
// Sequencer op queue for the SAA1099 scheduler.
// Registered level/full; flush beats push; sticky overflow.
module saa1099_op_fifo
  import saa1099_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  saa_op_t       din,
  output saa_op_t       dout,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  saa_op_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, ovf_q;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)
      level_d = level_q + 1'b1;
    else if (!do_push && do_pop)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset)
      mem_q[wr_q] <= din;
  end

  assign dout     = mem_q[rd_q];
  assign full     = full_q;
  assign overflow = ovf_q;
  assign level    = level_q;

endmodule

// File: rtl/saa1099_bus_sched.sv
// SAA1099 write-port scheduler: CPU vs sequencer round-robin,
// address/data phase sequencing with last-address caching.
module saa1099_bus_sched
  import saa1099_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int STROBE_LEN = 2,
  parameter int ADDR_CACHE = 1,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [4:0]    cpu_reg,
  input  logic [7:0]    cpu_data,
  input  logic          cpu_addr_only,
  output logic          cpu_ack,
  input  logic          seq_wr,
  input  logic [4:0]    seq_reg,
  input  logic [7:0]    seq_data,
  input  logic          seq_addr_only,
  input  logic          seq_flush,
  output logic          seq_full,
  output logic [LW-1:0] seq_level,
  output logic          seq_overflow,
  output logic          busy,
  output logic          saa_cs_n,
  output logic          saa_a0,
  output logic          saa_wr_n,
  output logic [7:0]    saa_din
);

  localparam int CW = $clog2(STROBE_LEN + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  saa_op_t       op_q, op_d, fifo_dout;
  logic          cache_v_q, cache_v_d;
  logic [4:0]    cache_reg_q, cache_reg_d;
  logic          pref_cpu_q, pref_cpu_d;
  logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic          a0_q, a0_d;
  logic [7:0]    din_q, din_d;
  logic          fifo_empty, grant_cpu, grant_fifo;

  saa1099_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk_sys),
    .reset    (reset),
    .push     (seq_wr),
    .pop      (grant_fifo),
    .flush    (seq_flush),
    .din      ({seq_addr_only, seq_reg, seq_data}),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (seq_full),
    .overflow (seq_overflow),
    .level    (seq_level)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    cache_v_d   = cache_v_q;
    cache_reg_d = cache_reg_q;
    pref_cpu_d  = pref_cpu_q;
    grant_cpu   = 1'b0;
    grant_fifo  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && (fifo_empty || pref_cpu_q))
          grant_cpu = 1'b1;
        else if (!fifo_empty)
          grant_fifo = 1'b1;
        if (grant_cpu || grant_fifo) begin
          op_d = grant_cpu ? {cpu_addr_only, cpu_reg, cpu_data}
                           : fifo_dout;
          pref_cpu_d = grant_fifo;
          // Address-only ops always strobe: they clock the envelope.
          if ((ADDR_CACHE != 0) && cache_v_q &&
              (op_d.rsel == cache_reg_q) && !op_d.addr_only)
            state_d = DATA_SETUP;
          else
            state_d = ADDR_SETUP;
        end
      end
      ADDR_SETUP: begin
        state_d = ADDR_STROBE;
        cnt_d   = '0;
      end
      ADDR_STROBE: begin
        if (cnt_q == CW'(STROBE_LEN - 1))
          state_d = ADDR_HOLD;
        else
          cnt_d = cnt_q + 1'b1;
      end
      ADDR_HOLD: begin
        cache_v_d   = 1'b1;
        cache_reg_d = op_q.rsel;
        state_d     = op_q.addr_only ? IDLE : DATA_SETUP;
      end
      DATA_SETUP: begin
        state_d = DATA_STROBE;
        cnt_d   = '0;
      end
      DATA_STROBE: begin
        if (cnt_q == CW'(STROBE_LEN - 1))
          state_d = DATA_HOLD;
        else
          cnt_d = cnt_q + 1'b1;
      end
      DATA_HOLD: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Bus pins are registered from the state being entered.
    cs_n_d = (state_d == IDLE);
    wr_n_d = !((state_d == ADDR_STROBE) || (state_d == DATA_STROBE));
    a0_d   = a0_q;
    din_d  = din_q;
    if (state_d == ADDR_SETUP) begin
      a0_d  = 1'b1;
      din_d = {3'b000, op_d.rsel};
    end else if (state_d == DATA_SETUP) begin
      a0_d  = 1'b0;
      din_d = op_d.data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      cache_v_q   <= 1'b0;
      cache_reg_q <= '0;
      pref_cpu_q  <= 1'b1;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      a0_q        <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      cache_v_q   <= cache_v_d;
      cache_reg_q <= cache_reg_d;
      pref_cpu_q  <= pref_cpu_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      a0_q        <= a0_d;
      din_q       <= din_d;
    end
  end

  assign cpu_ack  = grant_cpu && !reset;
  assign busy     = (state_q != IDLE);
  assign saa_cs_n = cs_n_q;
  assign saa_wr_n = wr_n_q;
  assign saa_a0   = a0_q;
  assign saa_din  = din_q;

endmodule
